// File: rtl/com_stream_port.sv
// Host-side load/run/dump controller: streams host words into shared data memory,
// launches the selected cores, waits for all of them, then streams a result window back.
module com_stream_port #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 12,
    parameter int N_CORES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  com_data_in,
    input  logic               data_write_start,
    input  logic               data_write_done,
    input  logic [N_CORES-1:0] n_cores,
    input  logic [ADDR_W-1:0]  out_base,
    input  logic [ADDR_W-1:0]  out_len,
    output logic [1:0]         state,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [N_CORES-1:0] core_start,
    input  logic [N_CORES-1:0] core_done,
    output logic [DATA_W-1:0]  com_data_out,
    output logic               com_data_valid,
    output logic               output_write_start,
    output logic               output_write_done,
    output logic               load_overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DUMP = 2'b11
    } state_t;

    state_t cur_state, next_state;

    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  base_q;
    logic [ADDR_W-1:0]  len_q;
    logic [ADDR_W:0]    len_ext;
    logic [ADDR_W:0]    dump_cnt;
    logic [N_CORES-1:0] mask_q;
    logic [N_CORES-1:0] done_seen;
    logic [N_CORES-1:0] done_now;
    logic               run_first;
    logic               load_word;
    logic               all_done;

    assign state              = cur_state;
    assign output_write_start = (cur_state == S_DUMP);
    // One extra bit so out_len + 1 (the final DUMP cycle index) never wraps.
    assign len_ext            = {1'b0, len_q};

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        next_state = cur_state;
        load_word  = 1'b0;
        wr_addr    = wr_ptr;
        done_now   = '0;
        all_done   = 1'b0;
        unique case (cur_state)
            S_IDLE: begin
                wr_addr = '0;
                if (data_write_start) begin
                    next_state = S_LOAD;
                    load_word  = 1'b1;
                end
            end
            S_LOAD: begin
                if (data_write_done) begin
                    next_state = S_RUN;
                end else if (data_write_start) begin
                    load_word = 1'b1;
                end
            end
            S_RUN: begin
                // Done inputs are ignored during the start-pulse cycle itself.
                if (!run_first) begin
                    done_now = core_done & mask_q;
                end
                all_done = ((done_seen | done_now) == mask_q);
                if (all_done) begin
                    next_state = S_DUMP;
                end
            end
            S_DUMP: begin
                if (dump_cnt == len_ext + 1'b1) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr            <= '0;
            base_q            <= '0;
            len_q             <= '0;
            mask_q            <= '0;
            done_seen         <= '0;
            run_first         <= 1'b0;
            dump_cnt          <= '0;
            mem_we            <= 1'b0;
            mem_addr          <= '0;
            mem_wdata         <= '0;
            core_start        <= '0;
            com_data_out      <= '0;
            com_data_valid    <= 1'b0;
            output_write_done <= 1'b0;
            load_overflow     <= 1'b0;
        end else begin
            mem_we            <= load_word;
            core_start        <= '0;
            com_data_valid    <= 1'b0;
            output_write_done <= 1'b0;

            if (load_word) begin
                mem_addr  <= wr_addr;
                mem_wdata <= com_data_in;
                wr_ptr    <= wr_addr + 1'b1;
            end

            if (cur_state == S_IDLE && data_write_start) begin
                load_overflow <= 1'b0;
            end else if (load_word && wr_addr == '1) begin
                load_overflow <= 1'b1;
            end

            unique case (cur_state)
                S_LOAD: begin
                    if (data_write_done) begin
                        mask_q     <= n_cores;
                        base_q     <= out_base;
                        len_q      <= out_len;
                        core_start <= n_cores;
                        done_seen  <= '0;
                        run_first  <= 1'b1;
                    end
                end
                S_RUN: begin
                    run_first <= 1'b0;
                    done_seen <= done_seen | done_now;
                    if (all_done) begin
                        mem_addr <= base_q;
                        dump_cnt <= '0;
                    end
                end
                S_DUMP: begin
                    // Cycle k issues address base+k; its word returns at k+1 and is registered out at k+2.
                    dump_cnt <= dump_cnt + 1'b1;
                    if (dump_cnt + 1'b1 < len_ext) begin
                        mem_addr <= mem_addr + 1'b1;
                    end
                    if (dump_cnt != '0 && dump_cnt <= len_ext) begin
                        com_data_valid <= 1'b1;
                        com_data_out   <= mem_rdata;
                    end
                    output_write_done <= (dump_cnt == len_ext);
                end
                default: ;
            endcase
        end
    end

endmodule
